// File: rtl/nibble_pair_arbiter_if.sv
// Handshake bundle between the three nibble sources, the arbiter and the wide sink.
// master is the arbiter side; slave is the environment (sources plus sink).
interface nibble_pair_arbiter_if #(
  parameter int P1 = 4,
  parameter int P2 = P1 * 2
);
  logic [P1-1:0] a1, a2, a3;
  logic          b1, b2, b3;
  logic          g1, g2, g3;
  logic [P2-1:0] h;
  logic          j;
  logic          e;
  logic [1:0]    f1;

  modport master (
    input  a1, a2, a3, b1, b2, b3, e,
    output g1, g2, g3, h, j, f1
  );

  modport slave (
    output a1, a2, a3, b1, b2, b3, e,
    input  g1, g2, g3, h, j, f1
  );
endinterface

// File: rtl/nibble_pair_arbiter.sv
// Round-robin arbiter over three nibble sources; each grant collects a low/high
// nibble pair into one word that is held on h until the sink accepts it.
module nibble_pair_arbiter #(
  parameter int P1 = 4,
  parameter int P2 = P1 * 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_pair_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, OUT} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    grant;
  logic [1:0]    f1_q;
  logic [2:0]    g_q;
  logic [P2-1:0] h_q;
  logic          j_q;

  logic [2:0]    req;
  logic [1:0]    cand1, cand2;
  logic          win_found;
  logic [1:0]    win_idx;
  logic [P1-1:0] nib;
  logic          sel_valid;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req   = {bus.b3, bus.b2, bus.b1};
  assign cand1 = inc3(ptr);
  assign cand2 = inc3(cand1);

  // Scan ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
  always_comb begin
    win_found = 1'b1;
    win_idx   = ptr;
    if (req[ptr])        win_idx = ptr;
    else if (req[cand1]) win_idx = cand1;
    else if (req[cand2]) win_idx = cand2;
    else                 win_found = 1'b0;
  end

  always_comb begin
    nib = bus.a1;
    case (grant)
      2'd1:    nib = bus.a2;
      2'd2:    nib = bus.a3;
      default: nib = bus.a1;
    endcase
  end

  assign sel_valid = req[grant];

  // Ready lines are registered alongside the state so no path exists from b or e to g.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      grant <= 2'd0;
      g_q   <= 3'b000;
      h_q   <= '0;
      j_q   <= 1'b0;
      f1_q  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= win_idx;
            ptr   <= inc3(win_idx);
            g_q   <= 3'b001 << win_idx;
            state <= LO;
          end
        end
        LO: begin
          if (sel_valid) begin
            h_q[P1-1:0] <= nib;
            state       <= HI;
          end
        end
        HI: begin
          if (sel_valid) begin
            h_q[P2-1:P1] <= nib;
            f1_q         <= grant;
            g_q          <= 3'b000;
            j_q          <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (bus.e) begin
            j_q   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.g1 = g_q[0];
  assign bus.g2 = g_q[1];
  assign bus.g3 = g_q[2];
  assign bus.h  = h_q;
  assign bus.j  = j_q;
  assign bus.f1 = f1_q;

endmodule

// File: tb/tb_nibble_pair_arbiter.sv
// Directed and randomized bench for nibble_pair_arbiter with a transaction-level
// reference model (lock owner, nibbles taken, pending word) checked every cycle.
module tb_nibble_pair_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  nibble_pair_arbiter_if #(.P1(4)) bus ();

  nibble_pair_arbiter #(.P1(4), .P2(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int         m_ptr;
  int         m_owner;
  int         m_cnt;
  int         m_src;
  bit         m_pend;
  logic [3:0] m_lo;
  logic [7:0] m_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_cnt   = 0;
    m_src   = 0;
    m_pend  = 1'b0;
    m_lo    = 4'h0;
    m_word  = 8'h00;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_update();
    logic [2:0] bv;
    logic [3:0] av [3];
    bit         found;
    int         idx;
    bv    = {bus.b3, bus.b2, bus.b1};
    av[0] = bus.a1;
    av[1] = bus.a2;
    av[2] = bus.a3;
    if (m_pend) begin
      if (bus.e) m_pend = 1'b0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (!found && bv[idx]) begin
          found   = 1'b1;
          m_owner = idx;
        end
      end
      if (found) begin
        m_ptr = (m_owner + 1) % 3;
        m_cnt = 0;
      end
    end else if (bv[m_owner]) begin
      if (m_cnt == 0) begin
        m_lo  = av[m_owner];
        m_cnt = 1;
      end else begin
        m_word  = {av[m_owner], m_lo};
        m_src   = m_owner;
        m_pend  = 1'b1;
        m_owner = -1;
      end
    end
  endtask

  task automatic m_check();
    logic [2:0] gv;
    logic [2:0] exp_g;
    gv    = {bus.g3, bus.g2, bus.g1};
    exp_g = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    chk("m_g", 32'(gv), 32'(exp_g));
    chk("m_onehot", 32'($countones(gv) <= 1), 32'd1);
    chk("m_j", 32'(bus.j), 32'(m_pend));
    if (m_pend) begin
      chk("m_h", 32'(bus.h), 32'(m_word));
      chk("m_f1", 32'(bus.f1), 32'(m_src));
    end
  endtask

  task automatic step();
    if (rst_n) m_update();
    else m_reset();
    @(posedge clk);
    #1;
    if (rst_n) m_check();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_g"}, 32'({bus.g3, bus.g2, bus.g1}), 32'd0);
    chk({tag, "_j"}, 32'(bus.j), 32'd0);
    chk({tag, "_h"}, 32'(bus.h), 32'd0);
    chk({tag, "_f1"}, 32'(bus.f1), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int         nw;
    logic [1:0] seq [3];
    tests  = 0;
    failed = 0;
    rst_n  = 1'b1;
    bus.a1 = 4'h0; bus.a2 = 4'h0; bus.a3 = 4'h0;
    bus.b1 = 1'b0; bus.b2 = 1'b0; bus.b3 = 1'b0;
    bus.e  = 1'b0;
    m_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single source: 4'h3 then 4'hA from requester 0
    bus.b1 = 1'b1; bus.a1 = 4'h3; bus.e = 1'b1;
    step();
    chk("t1_arb_g", 32'({bus.g3, bus.g2, bus.g1}), 32'b001);
    chk("t1_arb_j", 32'(bus.j), 32'd0);
    step();
    chk("t1_hi_g", 32'({bus.g3, bus.g2, bus.g1}), 32'b001);
    bus.a1 = 4'hA;
    step();
    chk("t1_j", 32'(bus.j), 32'd1);
    chk("t1_h", 32'(bus.h), 32'hA3);
    chk("t1_f1", 32'(bus.f1), 32'd0);
    chk("t1_out_g", 32'({bus.g3, bus.g2, bus.g1}), 32'd0);
    bus.b1 = 1'b0;
    step();
    chk("t1_j_fall", 32'(bus.j), 32'd0);

    // All valid after reset: grants rotate 0,1,2
    async_reset("rst2");
    bus.b1 = 1'b1; bus.b2 = 1'b1; bus.b3 = 1'b1; bus.e = 1'b1;
    nw = 0;
    for (int c = 0; c < 12; c++) begin
      bus.a1 = 4'($urandom); bus.a2 = 4'($urandom); bus.a3 = 4'($urandom);
      step();
      if (bus.j) begin
        if (nw < 3) seq[nw] = bus.f1;
        nw++;
      end
    end
    chk("t2_words", 32'(nw), 32'd3);
    chk("t2_seq0", 32'(seq[0]), 32'd0);
    chk("t2_seq1", 32'(seq[1]), 32'd1);
    chk("t2_seq2", 32'(seq[2]), 32'd2);
    bus.b1 = 1'b0; bus.b2 = 1'b0; bus.b3 = 1'b0;
    step();

    // Back-pressure: word C5 from requester 0 held while e=0
    bus.b1 = 1'b1; bus.a1 = 4'h5; bus.e = 1'b0;
    step();
    chk("t3_arb_g", 32'({bus.g3, bus.g2, bus.g1}), 32'b001);
    step();
    bus.a1 = 4'hC;
    step();
    bus.b1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_j", 32'(bus.j), 32'd1);
      chk("t3_hold_h", 32'(bus.h), 32'hC5);
      chk("t3_hold_f1", 32'(bus.f1), 32'd0);
      chk("t3_hold_g", 32'({bus.g3, bus.g2, bus.g1}), 32'd0);
      if (k == 4) bus.e = 1'b1;
      step();
    end
    chk("t3_j_fall", 32'(bus.j), 32'd0);

    // Stall in HI: requester 1 holds the lock while b2 is low
    bus.b1 = 1'b1; bus.b2 = 1'b1; bus.b3 = 1'b1;
    bus.a1 = 4'hF; bus.a2 = 4'h1; bus.a3 = 4'hF;
    step();
    chk("t4_arb_g", 32'({bus.g3, bus.g2, bus.g1}), 32'b010);
    step();
    bus.b2 = 1'b0; bus.a2 = 4'h7;
    step();
    chk("t4_stall_g0", 32'({bus.g3, bus.g2, bus.g1}), 32'b010);
    step();
    chk("t4_stall_g1", 32'({bus.g3, bus.g2, bus.g1}), 32'b010);
    step();
    chk("t4_stall_g2", 32'({bus.g3, bus.g2, bus.g1}), 32'b010);
    bus.b2 = 1'b1;
    step();
    chk("t4_j", 32'(bus.j), 32'd1);
    chk("t4_h", 32'(bus.h), 32'h71);
    chk("t4_f1", 32'(bus.f1), 32'd1);
    bus.b2 = 1'b0;

    // Wrap: ptr=2 with b1 and b3 valid, requester 2 wins, then requester 0
    step();
    chk("t5_idle_g", 32'({bus.g3, bus.g2, bus.g1}), 32'd0);
    bus.a3 = 4'h4;
    step();
    chk("t5_wrap_g", 32'({bus.g3, bus.g2, bus.g1}), 32'b100);
    step();
    bus.a3 = 4'h9;
    step();
    chk("t5_j", 32'(bus.j), 32'd1);
    chk("t5_h", 32'(bus.h), 32'h94);
    chk("t5_f1", 32'(bus.f1), 32'd2);
    step();
    step();
    chk("t5_ptr0_g", 32'({bus.g3, bus.g2, bus.g1}), 32'b001);
    step();
    chk("t6_pre_g", 32'({bus.g3, bus.g2, bus.g1}), 32'b001);

    // Async reset while in HI; ptr must restart at 0 (requester 0 beats 2)
    async_reset("rst6");
    bus.a1 = 4'h6;
    step();
    chk("t6_ptr0_g", 32'({bus.g3, bus.g2, bus.g1}), 32'b001);
    step();
    bus.a1 = 4'hE;
    step();
    chk("t6_j", 32'(bus.j), 32'd1);
    chk("t6_h", 32'(bus.h), 32'hE6);
    chk("t6_f1", 32'(bus.f1), 32'd0);
    bus.b1 = 1'b0; bus.b3 = 1'b0;
    step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      bus.b1 = ($urandom_range(0, 3) != 0);
      bus.b2 = ($urandom_range(0, 3) != 0);
      bus.b3 = ($urandom_range(0, 3) != 0);
      bus.a1 = 4'($urandom);
      bus.a2 = 4'($urandom);
      bus.a3 = 4'($urandom);
      bus.e  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
